axi4lite_reg_bridge: RTL and testbench
======================================

Name: axi4lite_reg_bridge

Overview:
Parametrised AXI4-Lite slave to register-bus bridge. It drives the register-map request/response signal set (bus_req … bus_err), replacing the fixed single-mode bridge. New capabilities: decoupled AW/W/AR capture, selectable read/write arbitration, byte-strobe to bit-enable expansion, and a response timeout that returns SLVERR. It sits between the SoC AXI4-Lite interconnect and the generated register map.

Parameters:
DATA_WIDTH, 32, data width; multiple of 8.
ADDR_WIDTH, 32, address width.
TIMEOUT_CYCLES, 256, max cycles from bus_req to bus_ready; 0 disables timeout.
ARB_MODE, 0, 0 = round-robin between read and write, 1 = read priority.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
s_awvalid/s_awready  in/out  1  AW handshake; s_awaddr  in  ADDR_WIDTH
s_wvalid/s_wready  in/out  1  W handshake; s_wdata  in  DATA_WIDTH; s_wstrb  in  DATA_WIDTH/8
s_bvalid/s_bready  out/in  1  B handshake; s_bresp  out  2
s_arvalid/s_arready  in/out  1  AR handshake; s_araddr  in  ADDR_WIDTH
s_rvalid/s_rready  out/in  1  R handshake; s_rdata  out  DATA_WIDTH; s_rresp  out  2
bus_req  out  1  single-cycle request strobe
bus_req_is_wr  out  1  1 = write
bus_addr  out  ADDR_WIDTH  request address
bus_wr_data  out  DATA_WIDTH  write data
bus_wr_biten  out  DATA_WIDTH  write bit enables
bus_req_stall_wr / bus_req_stall_rd  out  1  eligible write/read held behind the other direction
bus_ready  in  1  register map completion
bus_rd_data  in  DATA_WIDTH  read data, valid with bus_ready
bus_err  in  1  error, valid with bus_ready

Behaviour:
- Reset (rst low, async): FSM=IDLE; hold regs empty; all outputs 0, including s_*ready, s_bvalid, s_rvalid, bus_req, bus_addr, bus_wr_data, bus_wr_biten, stalls, resp fields and s_rdata.
- Capture: one-entry hold reg each for AW, W, AR. s_xready = !full (0 while rst low). Handshake sets full. full clears when the FSM issues that request. AW and W are independent; either order or the same cycle is accepted.
- Eligibility: write when AW&W full; read when AR full.
- FSM states: IDLE, REQ, WAIT, RESP_WR, RESP_RD.
- IDLE: if a write or read is eligible, pick one and load bus_* registers; next state REQ.
  - Both eligible, ARB_MODE=0: alternate, starting with write after reset.
  - Both eligible, ARB_MODE=1: read always wins.
- REQ: bus_req=1 for exactly one cycle; clear the served hold reg; timeout counter resets to 1.
  - bus_ready in REQ goes directly to RESP_*.
  - Otherwise go to WAIT.
- WAIT: counter increments each cycle.
  - bus_ready goes to RESP_*.
  - Counter == TIMEOUT_CYCLES (non-zero) goes to RESP_* flagged timeout.
  - bus_ready arriving in the same cycle as the timeout: bus_ready wins.
- RESP_WR: s_bvalid=1 until s_bready; s_bresp=2'b10 on bus_err or timeout, else 2'b00. Then IDLE.
- RESP_RD: s_rvalid=1; s_rdata = captured bus_rd_data, or 0 on error/timeout; s_rresp as for B. Held stable until s_rready, then IDLE.
- bus_ready while in IDLE/RESP (late or spurious): ignored.
- Read request fields: bus_req_is_wr=0, bus_wr_data=0, bus_wr_biten=0.
- Bit-enable expansion: bus_wr_biten[8i+7:8i] = {8{wstrb[i]}}.
- bus_req_stall_wr = write eligible && FSM not serving it; bus_req_stall_rd likewise. Both registered.
- Latency: the last of AW/W handshakes at edge N gives bus_req in cycle N+2 (capture, IDLE, REQ). bus_ready in REQ gives bvalid the next cycle.
- Throughput: one transaction in flight; new captures continue during service.
- s_bvalid/s_rvalid never drop before their handshake completes.

Decomposition:
- Package axi4lite_reg_pkg holds: resp_t (OKAY=2'b00, SLVERR=2'b10), bridge_state_t enum, ARB_RR/ARB_RD_PRIO constants.
- One sub-module: axi4lite_hold_reg (parametrised width, valid/ready capture, clear input), instantiated for AW, W (data+strb) and AR.

Test Plan:
- Write: AW 0x10, W 0xDEADBEEF, strb 4'b0011 -> bus_req_is_wr=1, bus_addr=0x10, bus_wr_biten=0x0000FFFF; bus_ready after 3 cycles -> bresp=0.
- W before AW by 5 cycles: wready drops after capture; AW 0x20 arrives -> one write to 0x20, bresp=OKAY.
- Read 0x04, map returns 0x12345678 with bus_err=1 -> rvalid, rdata=0, rresp=2'b10; hold s_rready=0 4 cycles -> outputs stable.
- TIMEOUT_CYCLES=8, never bus_ready -> bresp=2'b10 with bvalid exactly 9 cycles after bus_req; late bus_ready then ignored.
- Simultaneous eligible read and write: ARB_MODE=0 gives W,R,W,R across 4 pairs; ARB_MODE=1 serves the read first with bus_req_stall_wr=1 during it.
- Assert rst mid-WAIT -> all outputs 0 immediately, state IDLE, hold regs empty; post-reset write completes normally.

Source files
------------

// File: rtl/axi4lite_reg_pkg.sv
// Shared types for the AXI4-Lite to register-bus bridge.
package axi4lite_reg_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP_WR,
        ST_RESP_RD
    } bridge_state_t;

    localparam int ARB_RR      = 0;
    localparam int ARB_RD_PRIO = 1;

    function automatic resp_t to_resp(input logic err);
        return err ? SLVERR : OKAY;
    endfunction

endpackage

// File: rtl/axi4lite_hold_reg.sv
// One-entry valid/ready capture register; emptied by clr once the
// request it holds has been issued.
module axi4lite_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    output logic             ready,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic             full,
    output logic [WIDTH-1:0] dout
);
    logic             full_q, full_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (full_q) begin
            if (clr) full_d = 1'b0;
        end else if (valid && ready_q) begin
            full_d = 1'b1;
            data_d = din;
        end
        ready_d = !full_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign ready = ready_q;
    assign full  = full_q;
    assign dout  = data_q;

endmodule

// File: rtl/axi4lite_reg_bridge.sv
// AXI4-Lite slave to register-bus bridge with decoupled AW/W/AR capture,
// read/write arbitration and a completion timeout.
module axi4lite_reg_bridge
    import axi4lite_reg_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int          ARB_MODE       = ARB_RR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [1:0]              s_bresp,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    bus_req,
    output logic                    bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wr_data,
    output logic [DATA_WIDTH-1:0]   bus_wr_biten,
    output logic                    bus_req_stall_wr,
    output logic                    bus_req_stall_rd,
    input  logic                    bus_ready,
    input  logic [DATA_WIDTH-1:0]   bus_rd_data,
    input  logic                    bus_err
);
    localparam int          SW = DATA_WIDTH / 8;
    localparam logic [31:0] TO = TIMEOUT_CYCLES;

    logic                   aw_full, w_full, ar_full, clr_wr, clr_rd;
    logic [ADDR_WIDTH-1:0]  aw_addr, ar_addr;
    logic [DATA_WIDTH+SW-1:0] w_dout;
    logic [DATA_WIDTH-1:0]  strb_bits;

    bridge_state_t          state_q, state_d;
    logic                   rr_rd_q, rr_rd_d, is_wr_q, is_wr_d;
    logic                   bus_req_q, bus_req_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, biten_q, biten_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    resp_t                  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   stall_wr_q, stall_wr_d, stall_rd_q, stall_rd_d;
    logic                   wr_elig, rd_elig, pick_wr, done, err, serving;

    assign clr_wr = (state_q == ST_REQ) && is_wr_q;
    assign clr_rd = (state_q == ST_REQ) && !is_wr_q;

    axi4lite_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw (
        .clk(clk), .rst(rst), .valid(s_awvalid), .ready(s_awready),
        .din(s_awaddr), .clr(clr_wr), .full(aw_full), .dout(aw_addr)
    );

    axi4lite_hold_reg #(.WIDTH(DATA_WIDTH + SW)) u_w (
        .clk(clk), .rst(rst), .valid(s_wvalid), .ready(s_wready),
        .din({s_wstrb, s_wdata}), .clr(clr_wr), .full(w_full), .dout(w_dout)
    );

    axi4lite_hold_reg #(.WIDTH(ADDR_WIDTH)) u_ar (
        .clk(clk), .rst(rst), .valid(s_arvalid), .ready(s_arready),
        .din(s_araddr), .clr(clr_rd), .full(ar_full), .dout(ar_addr)
    );

    always_comb begin
        strb_bits = '0;
        for (int i = 0; i < SW; i++) strb_bits[8*i +: 8] = {8{w_dout[DATA_WIDTH+i]}};
    end

    always_comb begin
        state_d    = state_q;
        rr_rd_d    = rr_rd_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        biten_d    = biten_q;
        cnt_d      = cnt_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        bus_req_d  = 1'b0;
        pick_wr    = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        wr_elig    = aw_full && w_full;
        rd_elig    = ar_full;
        unique case (state_q)
            ST_IDLE: if (wr_elig || rd_elig) begin
                // rr_rd_q set means the read side has the next turn
                pick_wr   = wr_elig && (!rd_elig || (ARB_MODE == ARB_RR && !rr_rd_q));
                is_wr_d   = pick_wr;
                rr_rd_d   = pick_wr;
                bus_req_d = 1'b1;
                state_d   = ST_REQ;
                addr_d    = pick_wr ? aw_addr : ar_addr;
                wdata_d   = pick_wr ? w_dout[DATA_WIDTH-1:0] : '0;
                biten_d   = pick_wr ? strb_bits : '0;
            end
            ST_REQ: begin
                cnt_d = 32'd1;
                done  = bus_ready;
                err   = bus_err;
                if (!bus_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                done  = bus_ready || ((TO != 32'd0) && (cnt_q == TO));
                err   = bus_ready ? bus_err : 1'b1;
            end
            ST_RESP_WR: if (s_bready) begin
                bvalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
            ST_RESP_RD: if (s_rready) begin
                rvalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (done) begin
            if (is_wr_q) begin
                state_d  = ST_RESP_WR;
                bvalid_d = 1'b1;
                bresp_d  = to_resp(err);
            end else begin
                state_d  = ST_RESP_RD;
                rvalid_d = 1'b1;
                rresp_d  = to_resp(err);
                rdata_d  = err ? '0 : bus_rd_data;
            end
        end
        serving    = state_d != ST_IDLE;
        stall_wr_d = wr_elig && serving && !is_wr_d;
        stall_rd_d = rd_elig && serving && is_wr_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rr_rd_q    <= 1'b0;
            is_wr_q    <= 1'b0;
            bus_req_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            biten_q    <= '0;
            cnt_q      <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= OKAY;
            rdata_q    <= '0;
            stall_wr_q <= 1'b0;
            stall_rd_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_rd_q    <= rr_rd_d;
            is_wr_q    <= is_wr_d;
            bus_req_q  <= bus_req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            biten_q    <= biten_d;
            cnt_q      <= cnt_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            stall_wr_q <= stall_wr_d;
            stall_rd_q <= stall_rd_d;
        end
    end

    assign s_bvalid         = bvalid_q;
    assign s_bresp          = bresp_q;
    assign s_rvalid         = rvalid_q;
    assign s_rresp          = rresp_q;
    assign s_rdata          = rdata_q;
    assign bus_req          = bus_req_q;
    assign bus_req_is_wr    = is_wr_q;
    assign bus_addr         = addr_q;
    assign bus_wr_data      = wdata_q;
    assign bus_wr_biten     = biten_q;
    assign bus_req_stall_wr = stall_wr_q;
    assign bus_req_stall_rd = stall_rd_q;

endmodule

// File: tb/tb_axi4lite_reg_bridge.sv
// Directed bench: instance 0 round-robin, instance 1 read priority,
// both with an 8-cycle timeout and sharing the AXI stimulus.
module tb_axi4lite_reg_bridge;
    import axi4lite_reg_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        awvalid, wvalid, arvalid, bready, rready;
    logic [31:0] awaddr, araddr, wdata;
    logic [3:0]  wstrb;
    logic        man_ready, man_err, auto_rsp, arb_on;
    logic [31:0] man_rdata;

    logic [1:0]  awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bus_req, bus_req_is_wr, stall_wr, stall_rd, bus_ready;
    logic [1:0]  bresp [2];
    logic [1:0]  rresp [2];
    logic [31:0] rdata [2];
    logic [31:0] bus_addr [2];
    logic [31:0] bus_wdata [2];
    logic [31:0] bus_biten [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bus_ready[g] = auto_rsp ? bus_req[g] : man_ready;
        axi4lite_reg_bridge #(
            .DATA_WIDTH(32), .ADDR_WIDTH(32),
            .TIMEOUT_CYCLES(TO), .ARB_MODE(g)
        ) u_dut (
            .clk(clk), .rst(rst),
            .s_awvalid(awvalid), .s_awready(awready[g]), .s_awaddr(awaddr),
            .s_wvalid(wvalid), .s_wready(wready[g]), .s_wdata(wdata), .s_wstrb(wstrb),
            .s_bvalid(bvalid[g]), .s_bready(bready), .s_bresp(bresp[g]),
            .s_arvalid(arvalid), .s_arready(arready[g]), .s_araddr(araddr),
            .s_rvalid(rvalid[g]), .s_rready(rready), .s_rdata(rdata[g]), .s_rresp(rresp[g]),
            .bus_req(bus_req[g]), .bus_req_is_wr(bus_req_is_wr[g]),
            .bus_addr(bus_addr[g]), .bus_wr_data(bus_wdata[g]), .bus_wr_biten(bus_biten[g]),
            .bus_req_stall_wr(stall_wr[g]), .bus_req_stall_rd(stall_rd[g]),
            .bus_ready(bus_ready[g]), .bus_rd_data(man_rdata), .bus_err(man_err)
        );
    end

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        err;
        int          wait_c;
        logic [31:0] exp_biten;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];
    int   n_chk = 0;
    int   n_err = 0;
    logic g0 [$];
    logic g1 [$];
    logic s0 [$];
    logic s1 [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string ph);
        chk({ph, ".awready"}, awready[0], 0);
        chk({ph, ".wready"}, wready[0], 0);
        chk({ph, ".arready"}, arready[0], 0);
        chk({ph, ".bus_req"}, bus_req[0], 0);
        chk({ph, ".is_wr"}, bus_req_is_wr[0], 0);
        chk({ph, ".addr"}, bus_addr[0], 0);
        chk({ph, ".wdata"}, bus_wdata[0], 0);
        chk({ph, ".biten"}, bus_biten[0], 0);
        chk({ph, ".bvalid"}, bvalid[0], 0);
        chk({ph, ".rvalid"}, rvalid[0], 0);
        chk({ph, ".bresp"}, bresp[0], 0);
        chk({ph, ".rresp"}, rresp[0], 0);
        chk({ph, ".rdata"}, rdata[0], 0);
        chk({ph, ".stall_wr"}, stall_wr[0], 0);
        chk({ph, ".stall_rd"}, stall_rd[0], 0);
    endtask

    task automatic wait_idle(input string ph);
        int n = 0;
        while (!((&awready) && (&wready) && (&arready) && !(|bvalid) &&
                 !(|rvalid) && !(|bus_req)) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({ph, ".idle_wait_expired"}, n >= 60, 0);
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!bus_req[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_txn(input vec_t v, input string ph);
        int n;
        wait_idle(ph);
        if (v.is_wr) begin
            awaddr = v.addr; wdata = v.data; wstrb = v.strb;
            awvalid = 1'b1; wvalid = 1'b1;
        end else begin
            araddr = v.addr; arvalid = 1'b1;
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wait_req(n);
        chk({ph, ".req_latency"}, n, 1);
        chk({ph, ".is_wr"}, bus_req_is_wr[0], v.is_wr);
        chk({ph, ".addr"}, bus_addr[0], v.addr);
        chk({ph, ".wdata"}, bus_wdata[0], v.is_wr ? v.data : 32'h0);
        chk({ph, ".biten"}, bus_biten[0], v.exp_biten);
        repeat (v.wait_c) @(negedge clk);
        man_ready = 1'b1; man_err = v.err;
        man_rdata = v.is_wr ? 32'h0 : v.data;
        @(negedge clk);
        man_ready = 1'b0; man_err = 1'b0; man_rdata = 32'hFFFF_FFFF;
        if (v.is_wr) begin
            chk({ph, ".bvalid"}, bvalid[0], 1);
            chk({ph, ".bresp"}, bresp[0], v.exp_resp);
            bready = 1'b1;
            @(negedge clk);
            bready = 1'b0;
            chk({ph, ".bvalid_drop"}, bvalid[0], 0);
        end else begin
            chk({ph, ".rvalid"}, rvalid[0], 1);
            chk({ph, ".rresp"}, rresp[0], v.exp_resp);
            chk({ph, ".rdata"}, rdata[0], v.exp_rdata);
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
            chk({ph, ".rvalid_drop"}, rvalid[0], 0);
        end
    endtask

    always @(negedge clk) begin
        if (arb_on) begin
            if (bus_req[0]) begin
                g0.push_back(bus_req_is_wr[0]);
                s0.push_back(stall_rd[0]);
            end
            if (bus_req[1]) begin
                g1.push_back(bus_req_is_wr[1]);
                s1.push_back(stall_wr[1]);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{1, 32'h10, 32'hDEADBEEF, 4'b0011, 0, 3, 32'h0000FFFF, 2'b00, 32'h0};
        vecs[1] = '{1, 32'h14, 32'hCAFEF00D, 4'b1111, 0, 0, 32'hFFFFFFFF, 2'b00, 32'h0};
        vecs[2] = '{1, 32'h18, 32'h01234567, 4'b1010, 1, 1, 32'hFF00FF00, 2'b10, 32'h0};
        vecs[3] = '{0, 32'h04, 32'h12345678, 4'b0000, 0, 2, 32'h0, 2'b00, 32'h12345678};
        vecs[4] = '{0, 32'h08, 32'hA5A5A5A5, 4'b0000, 0, 0, 32'h0, 2'b00, 32'hA5A5A5A5};
        vecs[5] = '{1, 32'h1C, 32'h55555555, 4'b0100, 0, 7, 32'h00FF0000, 2'b00, 32'h0};
        vecs[6] = '{1, 32'h24, 32'h9ABCDEF0, 4'b1000, 0, 8, 32'hFF000000, 2'b00, 32'h0};
        vecs[7] = '{0, 32'h0C, 32'h87654321, 4'b0000, 0, 8, 32'h0, 2'b00, 32'h87654321};

        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        man_ready = 0; man_err = 0; man_rdata = 0; auto_rsp = 0; arb_on = 0;

        #1 check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Arbitration: four simultaneous write+read pairs
        auto_rsp = 1; bready = 1; rready = 1; arb_on = 1;
        for (int p = 0; p < 4; p++) begin
            wait_idle("arb");
            awaddr = 32'h100 + 32'(p * 4); wdata = 32'h1000 + 32'(p); wstrb = 4'hF;
            araddr = 32'h200 + 32'(p * 4);
            awvalid = 1; wvalid = 1; arvalid = 1;
            @(negedge clk);
            awvalid = 0; wvalid = 0; arvalid = 0;
        end
        wait_idle("arb_end");
        arb_on = 0; auto_rsp = 0; bready = 0; rready = 0;
        chk("arb.rr_count", g0.size(), 8);
        chk("arb.rp_count", g1.size(), 8);
        for (int i = 0; i < g0.size(); i++) begin
            chk($sformatf("arb.rr_grant%0d", i), g0[i], (i % 2) == 0);
            chk($sformatf("arb.rr_stall_rd%0d", i), s0[i], (i % 2) == 0);
        end
        for (int i = 0; i < g1.size(); i++) begin
            chk($sformatf("arb.rp_grant%0d", i), g1[i], (i % 2) == 1);
            chk($sformatf("arb.rp_stall_wr%0d", i), s1[i], (i % 2) == 0);
        end

        for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // W leads AW by five cycles
        wait_idle("w_first");
        wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        wvalid = 0;
        chk("w_first.wready_drop", wready[0], 0);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus_req[0]) n++;
        end
        chk("w_first.no_early_req", n, 0);
        awaddr = 32'h20; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        wait_req(n);
        chk("w_first.latency", n, 1);
        chk("w_first.addr", bus_addr[0], 32'h20);
        chk("w_first.is_wr", bus_req_is_wr[0], 1);
        chk("w_first.wdata", bus_wdata[0], 32'h0BADF00D);
        man_ready = 1;
        @(negedge clk);
        man_ready = 0;
        chk("w_first.bvalid", bvalid[0], 1);
        chk("w_first.bresp", bresp[0], 2'b00);
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("w_first.wready_back", wready[0], 1);

        // Read error, response held while rready is low
        wait_idle("rd_err");
        araddr = 32'h04; arvalid = 1;
        @(negedge clk);
        arvalid = 0;
        wait_req(n);
        chk("rd_err.latency", n, 1);
        man_ready = 1; man_err = 1; man_rdata = 32'h12345678;
        @(negedge clk);
        man_ready = 0; man_err = 0; man_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rd_err.rvalid%0d", i), rvalid[0], 1);
            chk($sformatf("rd_err.rdata%0d", i), rdata[0], 32'h0);
            chk($sformatf("rd_err.rresp%0d", i), rresp[0], 2'b10);
            if (i < 4) @(negedge clk);
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
        chk("rd_err.rvalid_drop", rvalid[0], 0);

        // Timeout, then late and spurious bus_ready
        wait_idle("tmo");
        awaddr = 32'h30; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        wait_req(n);
        n = 0;
        while (!bvalid[0] && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("tmo.bvalid_latency", n, 9);
        chk("tmo.bresp", bresp[0], 2'b10);
        man_ready = 1; man_err = 0;
        @(negedge clk);
        @(negedge clk);
        chk("tmo.late_bvalid", bvalid[0], 1);
        chk("tmo.late_bresp", bresp[0], 2'b10);
        bready = 1;
        @(negedge clk);
        bready = 0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_req[0] || bvalid[0]) n++;
        end
        man_ready = 0;
        chk("tmo.spurious_ignored", n, 0);

        // Reset while waiting on the register map
        wait_idle("rst");
        awaddr = 32'h40; wdata = 32'h99; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        wait_req(n);
        @(negedge clk);
        araddr = 32'h44; arvalid = 1;
        @(negedge clk);
        arvalid = 0;
        @(negedge clk);
        chk("rst.pre_stall_rd", stall_rd[0], 1);
        #2 rst = 1'b0;
        #1 check_zero("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.arready_back", arready[0], 1);
        chk("rst.awready_back", awready[0], 1);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus_req[0]) n++;
        end
        chk("rst.holds_empty", n, 0);
        do_txn(vecs[0], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
